// File: rtl/seg7_bcd_reader.sv
// Reads back a multiplexed 7-segment display: synchronizes segment/digit_sel,
// waits for a stable pattern, and decodes it into one hex register per digit.
module seg7_bcd_reader #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                segment,
    input  logic [NUM_DIGITS-1:0]     digit_sel,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      frame_done,
    output logic                      err
);

    typedef enum logic {
        SETTLE,
        HOLD
    } state_t;

    // The mismatch is seen one edge after the pair lands in stage 2, so the
    // capture compares against STABLE_CYCLES-2 to keep the overall latency at
    // STABLE_CYCLES+2 edges from the input change.
    localparam logic [7:0]            CAP_CNT  = 8'(STABLE_CYCLES - 2);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

    logic [NUM_DIGITS-1:0] sel_s1, sel_s2, sel_prev;
    logic [6:0]            seg_s1, seg_s2, seg_prev;
    logic [7:0]            cnt;
    state_t                state;
    logic [NUM_DIGITS-1:0] seen;
    logic [NUM_DIGITS-1:0] seen_next;
    logic                  pair_changed;
    logic                  sel_onehot;
    logic [3:0]            dec_code;
    logic                  dec_hit;

    assign pair_changed = (sel_s2 != sel_prev) || (seg_s2 != seg_prev);
    assign sel_onehot   = (sel_s2 != '0) && ((sel_s2 & (sel_s2 - SEL_ONE)) == '0);
    assign seen_next    = seen | sel_s2;

    always_comb begin
        dec_code = '0;
        dec_hit  = 1'b1;
        case (seg_s2)
            7'h7E: dec_code = 4'h0;
            7'h30: dec_code = 4'h1;
            7'h6D: dec_code = 4'h2;
            7'h79: dec_code = 4'h3;
            7'h33: dec_code = 4'h4;
            7'h5B: dec_code = 4'h5;
            7'h5F: dec_code = 4'h6;
            7'h70: dec_code = 4'h7;
            7'h7F: dec_code = 4'h8;
            7'h7B: dec_code = 4'h9;
            7'h77: dec_code = 4'hA;
            7'h1F: dec_code = 4'hB;
            7'h4E: dec_code = 4'hC;
            7'h3D: dec_code = 4'hD;
            7'h4F: dec_code = 4'hE;
            7'h47: dec_code = 4'hF;
            default: dec_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_s1      <= '0;
            sel_s2      <= '0;
            sel_prev    <= '0;
            seg_s1      <= '0;
            seg_s2      <= '0;
            seg_prev    <= '0;
            cnt         <= '0;
            state       <= SETTLE;
            seen        <= '0;
            bcd_out     <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            sel_s1     <= digit_sel;
            sel_s2     <= sel_s1;
            sel_prev   <= sel_s2;
            seg_s1     <= segment;
            seg_s2     <= seg_s1;
            seg_prev   <= seg_s2;
            err        <= 1'b0;
            frame_done <= 1'b0;

            if (pair_changed) begin
                cnt   <= '0;
                state <= SETTLE;
            end else if (state == SETTLE) begin
                if (cnt == CAP_CNT) begin
                    state <= HOLD;
                    if (sel_s2 != '0) begin
                        if (!sel_onehot) begin
                            err <= 1'b1;
                        end else begin
                            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                                if (sel_s2[i]) begin
                                    bcd_out[4*i +: 4] <= dec_hit ? dec_code : 4'h0;
                                    digit_valid[i]    <= dec_hit;
                                end
                            end
                            if (!dec_hit && (seg_s2 != '0))
                                err <= 1'b1;
                            if (seen_next == ALL_SEEN) begin
                                frame_done <= 1'b1;
                                seen       <= '0;
                            end else begin
                                seen <= seen_next;
                            end
                        end
                    end
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_bcd_reader.sv
// Bench for seg7_bcd_reader: directed scenarios plus a randomized stream,
// checked against a run-length reference model of the display reader.
module tb_seg7_bcd_reader;

    localparam int unsigned N = 4;
    localparam int unsigned S = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [6:0]       segment = '0;
    logic [N-1:0]     digit_sel = '0;
    logic [4*N-1:0]   bcd_out;
    logic [N-1:0]     digit_valid;
    logic             frame_done;
    logic             err;

    seg7_bcd_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .segment(segment),
        .digit_sel(digit_sel),
        .bcd_out(bcd_out),
        .digit_valid(digit_valid),
        .frame_done(frame_done),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a pattern is captured once its run of identical
    // input samples reaches S, seen two edges later through the synchronizer.
    logic [6:0]     seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                     7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    logic [4*N-1:0] m_bcd;
    logic [N-1:0]   m_valid, m_seen;
    logic           m_err, m_fd;
    logic [N+6:0]   p1_pair, p2_pair;
    int             p1_run, p2_run;

    int dut_err_n, mod_err_n, dut_fd_n, mod_fd_n;
    bit saw5;

    task automatic model_reset();
        m_bcd = '0; m_valid = '0; m_seen = '0; m_err = 1'b0; m_fd = 1'b0;
        p1_pair = '0; p2_pair = '0; p1_run = 1000; p2_run = 1000;
    endtask

    task automatic model_capture(input logic [N+6:0] pr);
        logic [N-1:0] sel;
        logic [6:0]   seg;
        int           idx, code;
        sel = pr[N+6:7];
        seg = pr[6:0];
        if (sel == '0) return;
        if ($countones(sel) != 1) begin
            m_err = 1'b1;
            return;
        end
        idx = 0;
        for (int i = 0; i < N; i++) if (sel[i]) idx = i;
        code = -1;
        for (int c = 0; c < 16; c++) if (seg_tab[c] == seg) code = c;
        if (code >= 0) begin
            m_bcd[4*idx +: 4] = 4'(code);
            m_valid[idx] = 1'b1;
        end else begin
            m_bcd[4*idx +: 4] = 4'h0;
            m_valid[idx] = 1'b0;
            if (seg != 7'h00) m_err = 1'b1;
        end
        m_seen[idx] = 1'b1;
        if (&m_seen) begin
            m_fd = 1'b1;
            m_seen = '0;
        end
    endtask

    task automatic model_step();
        logic [N+6:0] cur;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_err = 1'b0;
        m_fd  = 1'b0;
        if (p2_run == S) model_capture(p2_pair);
        p2_pair = p1_pair;
        p2_run  = p1_run;
        cur = {digit_sel, segment};
        if (cur == p1_pair) p1_run = (p1_run < 1000) ? p1_run + 1 : 1000;
        else begin
            p1_pair = cur;
            p1_run  = 1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            if (err)        dut_err_n++;
            if (m_err)      mod_err_n++;
            if (frame_done) dut_fd_n++;
            if (m_fd)       mod_fd_n++;
            if (bcd_out[3:0] == 4'd5) saw5 = 1'b1;
        end
    endtask

    task automatic clear_counts();
        dut_err_n = 0; mod_err_n = 0; dut_fd_n = 0; mod_fd_n = 0; saw5 = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        digit_sel = '0;
        segment = '0;
        model_reset();
        tick(2);
        rst_n = 1'b1;
        tick(1);
        clear_counts();
    endtask

    task automatic test_reset();
        digit_sel = 4'b0001;
        segment = 7'h30;
        rst_n = 1'b0;
        model_reset();
        tick(3);
        n_checks++;
        if (bcd_out !== '0) begin n_errors++; $display("FAIL reset_bcd: got %h expected 0", bcd_out); end
        n_checks++;
        if (digit_valid !== '0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", digit_valid); end
        n_checks++;
        if ({err, frame_done} !== 2'b00) begin n_errors++; $display("FAIL reset_pulses: got %b expected 00", {err, frame_done}); end
    endtask

    task automatic test_single();
        apply_reset();
        digit_sel = 4'b0001;
        segment = 7'h6D;
        tick(5);
        n_checks++;
        if (digit_valid !== 4'b0000) begin n_errors++; $display("FAIL single_early: got %b expected 0000", digit_valid); end
        tick(1);
        n_checks++;
        if (digit_valid !== 4'b0001) begin n_errors++; $display("FAIL single_valid: got %b expected 0001", digit_valid); end
        n_checks++;
        if (bcd_out[3:0] !== 4'h2) begin n_errors++; $display("FAIL single_value: got %h expected 2", bcd_out[3:0]); end
        tick(4);
        n_checks++;
        if (dut_err_n != 0) begin n_errors++; $display("FAIL single_err: got %0d pulses expected 0", dut_err_n); end
        n_checks++;
        if (bcd_out !== m_bcd) begin n_errors++; $display("FAIL single_model: got %h expected %h", bcd_out, m_bcd); end
    endtask

    task automatic test_frame();
        logic [6:0] pats [4] = '{7'h7E, 7'h30, 7'h79, 7'h47};
        apply_reset();
        for (int d = 0; d < 4; d++) begin
            digit_sel = '0;
            digit_sel[d] = 1'b1;
            segment = pats[d];
            if (d < 3) tick(8);
            else begin
                tick(5);
                n_checks++;
                if (frame_done !== 1'b0) begin n_errors++; $display("FAIL frame_early: got %b expected 0", frame_done); end
                tick(1);
                n_checks++;
                if (frame_done !== 1'b1) begin n_errors++; $display("FAIL frame_pulse: got %b expected 1", frame_done); end
                tick(2);
            end
        end
        n_checks++;
        if (bcd_out !== 16'hF310) begin n_errors++; $display("FAIL frame_bcd: got %h expected F310", bcd_out); end
        n_checks++;
        if (digit_valid !== 4'b1111) begin n_errors++; $display("FAIL frame_valid: got %b expected 1111", digit_valid); end
        n_checks++;
        if (dut_fd_n != 1 || mod_fd_n != 1) begin n_errors++; $display("FAIL frame_count: got %0d expected 1", dut_fd_n); end
    endtask

    task automatic test_err();
        logic [4*N-1:0] saved_bcd;
        logic [N-1:0]   saved_valid;
        apply_reset();
        digit_sel = 4'b0010;
        segment = 7'h7B;
        tick(8);
        n_checks++;
        if (bcd_out[7:4] !== 4'h9) begin n_errors++; $display("FAIL err_setup: got %h expected 9", bcd_out[7:4]); end
        clear_counts();
        segment = 7'h2A;
        tick(8);
        n_checks++;
        if (dut_err_n != 1) begin n_errors++; $display("FAIL err_bad_seg: got %0d pulses expected 1", dut_err_n); end
        n_checks++;
        if (digit_valid[1] !== 1'b0 || bcd_out[7:4] !== 4'h0) begin
            n_errors++; $display("FAIL err_cleared: got valid %b value %h expected 0 0", digit_valid[1], bcd_out[7:4]);
        end
        saved_bcd = bcd_out;
        saved_valid = digit_valid;
        clear_counts();
        digit_sel = 4'b0110;
        tick(8);
        n_checks++;
        if (dut_err_n != 1) begin n_errors++; $display("FAIL err_multihot: got %0d pulses expected 1", dut_err_n); end
        n_checks++;
        if (bcd_out !== saved_bcd || digit_valid !== saved_valid) begin
            n_errors++; $display("FAIL err_nowrite: got %h/%b expected %h/%b", bcd_out, digit_valid, saved_bcd, saved_valid);
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        digit_sel = 4'b0001;
        segment = 7'h5B;
        tick(3);
        segment = 7'h1F;
        tick(8);
        n_checks++;
        if (saw5) begin n_errors++; $display("FAIL glitch_seen: got value 5 expected never"); end
        n_checks++;
        if (bcd_out[3:0] !== 4'hB || digit_valid[0] !== 1'b1) begin
            n_errors++; $display("FAIL glitch_final: got %h/%b expected b/1", bcd_out[3:0], digit_valid[0]);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        digit_sel = 4'b0010;
        segment = 7'h7B;
        tick(8);
        digit_sel = 4'b0001;
        segment = 7'h30;
        tick(4);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bcd_out !== '0 || digit_valid !== '0) begin
            n_errors++; $display("FAIL midreset_clear: got %h/%b expected 0/0", bcd_out, digit_valid);
        end
        tick(1);
        rst_n = 1'b1;
        tick(5);
        n_checks++;
        if (digit_valid !== 4'b0000) begin n_errors++; $display("FAIL midreset_early: got %b expected 0000", digit_valid); end
        tick(1);
        n_checks++;
        if (digit_valid !== 4'b0001 || bcd_out !== 16'h0001) begin
            n_errors++; $display("FAIL midreset_capture: got %h/%b expected 0001/0001", bcd_out, digit_valid);
        end
    endtask

    task automatic test_blank();
        apply_reset();
        digit_sel = 4'b0100;
        segment = 7'h4F;
        tick(8);
        n_checks++;
        if (digit_valid[2] !== 1'b1 || bcd_out[11:8] !== 4'hE) begin
            n_errors++; $display("FAIL blank_setup: got %b/%h expected 1/E", digit_valid[2], bcd_out[11:8]);
        end
        clear_counts();
        segment = 7'h00;
        tick(8);
        n_checks++;
        if (digit_valid[2] !== 1'b0 || bcd_out[11:8] !== 4'h0) begin
            n_errors++; $display("FAIL blank_clear: got %b/%h expected 0/0", digit_valid[2], bcd_out[11:8]);
        end
        n_checks++;
        if (dut_err_n != 0) begin n_errors++; $display("FAIL blank_err: got %0d pulses expected 0", dut_err_n); end
    endtask

    task automatic test_random();
        int k, s, hold;
        apply_reset();
        for (int w = 0; w < 80; w++) begin
            k = $urandom_range(0, 9);
            digit_sel = '0;
            if (k == 1) begin
                digit_sel = 4'($urandom_range(0, 15));
                if ($countones(digit_sel) < 2) digit_sel = 4'b1010;
            end else if (k != 0) begin
                digit_sel[$urandom_range(0, N-1)] = 1'b1;
            end
            s = $urandom_range(0, 9);
            if (s == 0) segment = 7'h00;
            else if (s == 1) segment = 7'h2A;
            else segment = seg_tab[$urandom_range(0, 15)];
            hold = $urandom_range(1, 8);
            for (int c = 0; c < hold; c++) begin
                tick(1);
                n_checks++;
                if ({bcd_out, digit_valid, err, frame_done} !== {m_bcd, m_valid, m_err, m_fd}) begin
                    n_errors++;
                    $display("FAIL random_w%0d: got %h/%b/%b/%b expected %h/%b/%b/%b", w,
                             bcd_out, digit_valid, err, frame_done, m_bcd, m_valid, m_err, m_fd);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        clear_counts();
        test_reset();
        test_single();
        test_frame();
        test_err();
        test_glitch();
        test_reset_mid();
        test_blank();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
